// File: rtl/mintz80_pager_pkg.sv
// Shared constants and types for the MinTZ80 pager: register offsets, unlock keys
// and the lock state encoding.
package mintz80_pager_pkg;

  localparam logic [3:0] OFS_BEEP  = 4'd0;
  localparam logic [3:0] OFS_LOCK  = 4'd1;
  localparam logic [3:0] OFS_INDEX = 4'd2;
  localparam logic [3:0] OFS_DATA  = 4'd3;

  localparam logic [7:0] KEY1_VAL = 8'hA5;
  localparam logic [7:0] KEY2_VAL = 8'h5A;

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    KEY1     = 2'd1,
    UNLOCKED = 2'd2
  } lock_state_t;

endpackage

// File: rtl/mintz80_pager_if.sv
// Z80-side bus bundle for the pager: strobes and address in, bank/enables/selects out.
// The tri-state data bus is kept as a plain port on the pager itself.
interface mintz80_pager_if #(
  parameter int WIN_BITS  = 3,
  parameter int BANK_BITS = 6
);
  logic                 rd_n;
  logic                 wr_n;
  logic                 mreq_n;
  logic                 iorq_n;
  logic [7:0]           a_lo;
  logic [WIN_BITS-1:0]  a_hi;
  logic [BANK_BITS-1:0] bank;
  logic                 romen_n;
  logic                 ramen_n;
  logic                 extio_n;
  logic                 beep;

  modport master (
    output rd_n, wr_n, mreq_n, iorq_n, a_lo, a_hi,
    input  bank, romen_n, ramen_n, extio_n, beep
  );

  modport slave (
    input  rd_n, wr_n, mreq_n, iorq_n, a_lo, a_hi,
    output bank, romen_n, ramen_n, extio_n, beep
  );
endinterface

// File: rtl/mintz80_strobe_sync.sv
// Two-flop synchroniser for an active-high Z80 strobe plus a one-clk edge pulse,
// either on assertion (DETECT_ASSERT=1) or on de-assertion (DETECT_ASSERT=0).
module mintz80_strobe_sync #(
  parameter bit DETECT_ASSERT = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe_i,
  output logic pulse_o
);
  logic armed_q;
  logic s1_q;
  logic s2_q;
  logic s3_q;

  // The chain only accepts the strobe once it has been seen idle after reset, so an
  // access already in progress across reset release never produces an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed_q <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
    end else begin
      armed_q <= armed_q | ~strobe_i;
      s1_q    <= strobe_i & armed_q;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
    end
  end

  assign pulse_o = DETECT_ASSERT ? (s2_q & ~s3_q) : (~s2_q & s3_q);
endmodule

// File: rtl/mintz80_pager.sv
// MinTZ80 memory pager: window-to-bank map, ROM/RAM enables, keyed unlock and indexed
// register access. Optional tone generator enabled by defining MINTZ80_PAGER_TONE_EN.
module mintz80_pager
  import mintz80_pager_pkg::*;
#(
  parameter int         WIN_BITS  = 3,
  parameter int         BANK_BITS = 6,
  parameter logic [3:0] IO_BASE   = 4'hD,
  parameter int         ROM_BANKS = 1
) (
  input  logic             clk,
  input  logic             reset,
  mintz80_pager_if.slave   bus,
  inout  wire  [7:0]       data
);
  localparam int NWIN = 1 << WIN_BITS;
  localparam logic [BANK_BITS:0] ROM_LIM = (BANK_BITS + 1)'(ROM_BANKS);

  logic [BANK_BITS-1:0] map_q [NWIN];
  logic [WIN_BITS-1:0]  index_q;
  lock_state_t          lock_q;
  logic [3:0]           rd_ofs_q;
  logic                 beep_q;

  logic       io_hit;
  logic [3:0] ofs;
  logic       wr_ev;
  logic       rd_ev;
  logic [7:0] rd_data;
  logic       rd_drive;

  assign ofs    = bus.a_lo[3:0];
  assign io_hit = !bus.iorq_n && (bus.a_lo[7:4] == IO_BASE);

  assign bus.bank    = map_q[bus.a_hi];
  assign bus.romen_n = bus.mreq_n | ({1'b0, bus.bank} >= ROM_LIM);
  assign bus.ramen_n = bus.mreq_n | ({1'b0, bus.bank} <  ROM_LIM);
  assign bus.extio_n = !(io_hit && (ofs[3:2] == 2'b01));
  assign bus.beep    = beep_q;

  mintz80_strobe_sync #(.DETECT_ASSERT(1'b1)) u_wr_sync (
    .clk      (clk),
    .reset    (reset),
    .strobe_i (io_hit & !bus.wr_n),
    .pulse_o  (wr_ev)
  );

  mintz80_strobe_sync #(.DETECT_ASSERT(1'b0)) u_rd_sync (
    .clk      (clk),
    .reset    (reset),
    .strobe_i (io_hit & !bus.rd_n),
    .pulse_o  (rd_ev)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NWIN; i++) map_q[i] <= BANK_BITS'(i);
      index_q  <= '0;
      lock_q   <= LOCKED;
      rd_ofs_q <= '0;
    end else begin
      if (io_hit && !bus.rd_n) rd_ofs_q <= ofs;
      if (wr_ev) begin
        case (ofs)
          OFS_LOCK: begin
            case (lock_q)
              LOCKED:  lock_q <= (data == KEY1_VAL) ? KEY1 : LOCKED;
              KEY1:    lock_q <= (data == KEY2_VAL) ? UNLOCKED : LOCKED;
              default: lock_q <= LOCKED;
            endcase
          end
          OFS_INDEX: index_q <= data[WIN_BITS-1:0];
          OFS_DATA: begin
            if (lock_q == UNLOCKED) map_q[index_q] <= data[BANK_BITS-1:0];
            index_q <= index_q + WIN_BITS'(1);
          end
          default: ;
        endcase
      end else if (rd_ev && (rd_ofs_q == OFS_DATA)) begin
        index_q <= index_q + WIN_BITS'(1);
      end
    end
  end

`ifdef MINTZ80_PAGER_TONE_EN
  logic [7:0]  div_q;
  logic [15:0] cnt_q;

  // Half period is divisor*16 clks; a fresh divisor restarts the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q  <= '0;
      cnt_q  <= '0;
      beep_q <= 1'b0;
    end else if (wr_ev && (ofs == OFS_BEEP)) begin
      div_q <= data;
      cnt_q <= '0;
    end else if (div_q == 8'd0) begin
      cnt_q  <= '0;
      beep_q <= 1'b0;
    end else if (cnt_q == ({4'b0, div_q, 4'b0} - 16'd1)) begin
      cnt_q  <= '0;
      beep_q <= ~beep_q;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) beep_q <= 1'b0;
    else if (wr_ev && (ofs == OFS_BEEP)) beep_q <= ~beep_q;
  end
`endif

  always_comb begin
    rd_data  = 8'h00;
    rd_drive = 1'b0;
    if (io_hit && !bus.rd_n) begin
      rd_drive = 1'b1;
      case (ofs)
        OFS_LOCK:  rd_data = {6'b0, lock_q == KEY1, lock_q == UNLOCKED};
        OFS_INDEX: rd_data = 8'(index_q);
        OFS_DATA:  rd_data = 8'(map_q[index_q]);
`ifdef MINTZ80_PAGER_TONE_EN
        OFS_BEEP:  rd_data = div_q;
`endif
        default:   rd_drive = 1'b0;
      endcase
    end
  end

  assign data = rd_drive ? rd_data : 8'hzz;
endmodule

// File: tb/tb_mintz80_pager.sv
// Table-driven bench for mintz80_pager: Z80 memory/I/O cycles with a scoreboard queue
// of expected values, plus hand sequences for beep, reset mid-write and the tone option.
module tb_mintz80_pager;
  localparam int WIN_BITS  = 3;
  localparam int BANK_BITS = 6;

  typedef enum logic [2:0] {OP_MEM, OP_MEMI, OP_IOW, OP_IOR, OP_NDR, OP_IDLE} op_t;

  typedef struct {
    op_t         op;
    logic [15:0] addr;
    logic [7:0]  wdat;
    logic [7:0]  exp;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [7:0] tb_dat;
  logic       tb_oe;
  wire  [7:0] data;

  int n_vec;
  int n_mis;
  logic [7:0] sb[$];
  vec_t vecs[$];

  assign data = tb_oe ? tb_dat : 8'hzz;

  mintz80_pager_if #(.WIN_BITS(WIN_BITS), .BANK_BITS(BANK_BITS)) bus ();

  mintz80_pager #(
    .WIN_BITS  (WIN_BITS),
    .BANK_BITS (BANK_BITS),
    .IO_BASE   (4'hD),
    .ROM_BANKS (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .data  (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [15:0] got, input logic [15:0] want);
    n_vec++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic logic exp_extio(input logic [7:0] a);
    return !((a[7:4] == 4'hD) && (a[3:0] >= 4'd4) && (a[3:0] <= 4'd7));
  endfunction

  function automatic void add(input op_t op, input logic [15:0] addr,
                              input logic [7:0] wdat, input logic [7:0] exp);
    vec_t v;
    v.op = op; v.addr = addr; v.wdat = wdat; v.exp = exp;
    vecs.push_back(v);
  endfunction

  task automatic apply(input vec_t v, input int k);
    logic [7:0] got;
    logic [7:0] want;
    got = 8'h00;
    @(negedge clk);
    bus.a_lo = v.addr[7:0];
    bus.a_hi = v.addr[15:16-WIN_BITS];
    case (v.op)
      OP_MEM, OP_MEMI: begin
        bus.mreq_n = (v.op == OP_MEMI);
        sb.push_back(v.exp);
        @(negedge clk);
        got = {bus.romen_n, bus.ramen_n, bus.bank};
        bus.mreq_n = 1'b1;
      end
      OP_IOW:  begin tb_dat = v.wdat; tb_oe = 1'b1; bus.iorq_n = 1'b0; bus.wr_n = 1'b0; end
      OP_IOR:  begin tb_oe = 1'b0; bus.iorq_n = 1'b0; bus.rd_n = 1'b0; sb.push_back(v.exp); end
      OP_NDR:  begin tb_dat = 8'h00; tb_oe = 1'b1; bus.iorq_n = 1'b0; bus.rd_n = 1'b0; sb.push_back(v.exp); end
      default: begin tb_dat = 8'h00; tb_oe = 1'b1; bus.iorq_n = 1'b0; sb.push_back(v.exp); end
    endcase
    if (v.op != OP_MEM && v.op != OP_MEMI) begin
      repeat (2) @(negedge clk);
      cmp("extio_n", {15'b0, bus.extio_n}, {15'b0, exp_extio(v.addr[7:0])});
      if (v.op != OP_IOW) got = data;
      repeat (2) @(negedge clk);
      bus.wr_n = 1'b1; bus.rd_n = 1'b1; bus.iorq_n = 1'b1; tb_oe = 1'b0;
      repeat (4) @(negedge clk);
    end
    if (v.op != OP_IOW) begin
      want = sb.pop_front();
      $display("vec %0d op=%s addr=%04h got=%02h exp=%02h", k, v.op.name(), v.addr, got, want);
      cmp($sformatf("vec%0d", k), {8'h00, got}, {8'h00, want});
    end else begin
      $display("vec %0d op=%s addr=%04h wdat=%02h", k, v.op.name(), v.addr, v.wdat);
    end
  endtask

  task automatic run(input op_t op, input logic [15:0] addr, input logic [7:0] wdat,
                     input logic [7:0] exp, input int k);
    vec_t v;
    v.op = op; v.addr = addr; v.wdat = wdat; v.exp = exp;
    apply(v, k);
  endtask

  initial begin
    logic beep_m;
    n_vec = 0; n_mis = 0;
    reset = 1'b0; tb_oe = 1'b0; tb_dat = 8'h00;
    bus.rd_n = 1'b1; bus.wr_n = 1'b1; bus.mreq_n = 1'b1; bus.iorq_n = 1'b1;
    bus.a_lo = 8'h00; bus.a_hi = '0;

    // Expected memory result is {romen_n, ramen_n, bank[5:0]}
    add(OP_MEM,  16'h0000, 8'h00, 8'h40);
    add(OP_MEM,  16'hE000, 8'h00, 8'h87);
    add(OP_MEM,  16'h2000, 8'h00, 8'h81);
    add(OP_MEMI, 16'hE000, 8'h00, 8'hC7);
    add(OP_IOR,  16'h00D1, 8'h00, 8'h00);
    add(OP_IOR,  16'h00D2, 8'h00, 8'h00);
    add(OP_IOW,  16'h00D2, 8'h02, 8'h00);
    add(OP_IOW,  16'h00D3, 8'h15, 8'h00);
    add(OP_IOR,  16'h00D2, 8'h00, 8'h03);
    add(OP_IOR,  16'h00D1, 8'h00, 8'h00);
    add(OP_MEM,  16'h4000, 8'h00, 8'h82);
    add(OP_IOW,  16'h00D1, 8'hA5, 8'h00);
    add(OP_IOR,  16'h00D1, 8'h00, 8'h02);
    add(OP_IOW,  16'h00D1, 8'h5A, 8'h00);
    add(OP_IOR,  16'h00D1, 8'h00, 8'h01);
    add(OP_IOW,  16'h00D2, 8'h07, 8'h00);
    add(OP_IOW,  16'h00D3, 8'h3F, 8'h00);
    add(OP_IOW,  16'h00D3, 8'h04, 8'h00);
    add(OP_IOR,  16'h00D2, 8'h00, 8'h01);
    add(OP_MEM,  16'h0000, 8'h00, 8'h84);
    add(OP_MEM,  16'hE000, 8'h00, 8'hBF);
    add(OP_MEMI, 16'hE000, 8'h00, 8'hFF);
    add(OP_IOW,  16'h00D2, 8'h07, 8'h00);
    add(OP_IOR,  16'h00D3, 8'h00, 8'h3F);
    add(OP_IOR,  16'h00D3, 8'h00, 8'h04);
    add(OP_IOR,  16'h00D2, 8'h00, 8'h01);
    add(OP_IOW,  16'h00D1, 8'h00, 8'h00);
    add(OP_IOR,  16'h00D1, 8'h00, 8'h00);
    add(OP_IOW,  16'h00D1, 8'hA5, 8'h00);
    add(OP_IOW,  16'h00D2, 8'h01, 8'h00);
    add(OP_IOR,  16'h00D1, 8'h00, 8'h02);
    add(OP_IOW,  16'h00D1, 8'h5A, 8'h00);
    add(OP_IOR,  16'h00D1, 8'h00, 8'h01);
    add(OP_IOW,  16'h00D1, 8'hA5, 8'h00);
    add(OP_IOW,  16'h00D1, 8'hA5, 8'h00);
    add(OP_IOW,  16'h00D1, 8'h77, 8'h00);
    add(OP_IOR,  16'h00D1, 8'h00, 8'h00);
    add(OP_IOW,  16'h00D1, 8'hA5, 8'h00);
    add(OP_IOW,  16'h00D1, 8'h5A, 8'h00);
    add(OP_IOW,  16'h00D2, 8'h03, 8'h00);
    add(OP_IOW,  16'h00D3, 8'h2A, 8'h00);
    add(OP_IOW,  16'h00D1, 8'h00, 8'h00);
    add(OP_IOW,  16'h00D2, 8'h01, 8'h00);
    add(OP_IOR,  16'h00D3, 8'h00, 8'h01);
    add(OP_IOR,  16'h00D3, 8'h00, 8'h02);
    add(OP_IOR,  16'h00D3, 8'h00, 8'h2A);
    add(OP_IOR,  16'h00D2, 8'h00, 8'h04);
    add(OP_IOW,  16'h00D4, 8'h00, 8'h00);
    add(OP_IOW,  16'h00C2, 8'h00, 8'h00);
    add(OP_IOR,  16'h00D2, 8'h00, 8'h04);
    add(OP_NDR,  16'h00D9, 8'h00, 8'h00);
    add(OP_NDR,  16'h00D5, 8'h00, 8'h00);
    add(OP_NDR,  16'h00C3, 8'h00, 8'h00);
    add(OP_IDLE, 16'h00D3, 8'h00, 8'h00);
`ifndef MINTZ80_PAGER_TONE_EN
    add(OP_NDR,  16'h00D0, 8'h00, 8'h00);
`endif

    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    cmp("beep_reset", {15'b0, bus.beep}, 16'h0000);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

`ifndef MINTZ80_PAGER_TONE_EN
    beep_m = 1'b0;
    for (int i = 0; i < 2; i++) begin
      run(OP_IOW, 16'h00D0, 8'h00, 8'h00, 100 + i);
      beep_m = ~beep_m;
      cmp("beep_toggle", {15'b0, bus.beep}, {15'b0, beep_m});
    end
`endif

    // Reset while a DATA write is held low across the release
    run(OP_IOW, 16'h00D1, 8'hA5, 8'h00, 200);
    run(OP_IOW, 16'h00D1, 8'h5A, 8'h00, 201);
    run(OP_IOW, 16'h00D2, 8'h05, 8'h00, 202);
    run(OP_IOW, 16'h00D3, 8'h2C, 8'h00, 203);
    run(OP_IOW, 16'h00D2, 8'h05, 8'h00, 204);
    run(OP_MEM, 16'hA000, 8'h00, 8'hAC, 205);
    @(negedge clk);
    bus.a_lo = 8'hD3; tb_dat = 8'h11; tb_oe = 1'b1; bus.iorq_n = 1'b0; bus.wr_n = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    bus.wr_n = 1'b1; bus.iorq_n = 1'b1; tb_oe = 1'b0;
    repeat (4) @(negedge clk);
    $display("reset asserted during DATA write, released with wr_n low");
    run(OP_IOR, 16'h00D2, 8'h00, 8'h00, 206);
    run(OP_IOR, 16'h00D1, 8'h00, 8'h00, 207);
    run(OP_MEM, 16'hA000, 8'h00, 8'h85, 208);
    run(OP_MEM, 16'h0000, 8'h00, 8'h40, 209);
    run(OP_MEM, 16'hE000, 8'h00, 8'h87, 210);

`ifdef MINTZ80_PAGER_TONE_EN
    begin
      int t[3];
      int nt;
      logic prev;
      run(OP_IOW, 16'h00D0, 8'h01, 8'h00, 300);
      run(OP_IOR, 16'h00D0, 8'h00, 8'h01, 301);
      nt = 0;
      prev = bus.beep;
      for (int c = 0; c < 200 && nt < 3; c++) begin
        @(negedge clk);
        if (bus.beep !== prev) begin
          t[nt] = c;
          nt++;
        end
        prev = bus.beep;
      end
      cmp("tone_edges", 16'(nt), 16'd3);
      if (nt == 3) begin
        $display("tone half=%0d period=%0d clk", t[1] - t[0], t[2] - t[0]);
        cmp("tone_half", 16'(t[1] - t[0]), 16'd16);
        cmp("tone_period", 16'(t[2] - t[0]), 16'd32);
      end
      run(OP_IOW, 16'h00D0, 8'h00, 8'h00, 302);
      repeat (3) @(negedge clk);
      cmp("tone_off", {15'b0, bus.beep}, 16'h0000);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
